// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: opcode width, default reset PC, fetch FSM encodings, buffer depth.
// FETCH_PREFETCH_EN selects a 2-entry prefetch buffer; otherwise a single entry.
package fetch_unit_pkg;

   localparam int OPCODE_W         = 5;
   localparam int RESET_PC_DEFAULT = 0;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

`ifdef FETCH_PREFETCH_EN
   localparam int FETCH_DEPTH = 2;
`else
   localparam int FETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_unit_buf.sv
// Shift-register FIFO (depth 1 or 2) holding fetched {pc, instr} words for decode.
// Entry 0 is always the head, so the head drives decode straight from a flop.
module fetch_unit_buf
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int W     = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [W-1:0]     head,
   output logic             empty,
   output logic [CNT_W-1:0] cnt_nxt
);

   logic [W-1:0]     ent_q [DEPTH];
   logic [W-1:0]     ent_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_pop, do_push;
   int               wr_idx;

   assign do_pop  = pop && (cnt_q != '0);
   assign do_push = push && (do_pop || (cnt_q != CNT_W'(DEPTH)));
   assign wr_idx  = int'(cnt_q) - (do_pop ? 1 : 0);

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (i == wr_idx)) ent_d[i] = push_data;
         end
         cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         ent_q <= ent_d;
      end
   end

   assign head    = ent_q[0];
   assign empty   = (cnt_q == '0);
   assign cnt_nxt = cnt_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, one-outstanding imem reads, redirects, decode handshake.
// Buffer depth set by FETCH_PREFETCH_EN (2 entries when defined, 1 otherwise).
//
//  state      | meaning
//  FETCH_REQ  | idle / requesting imem_addr=pc when the buffer has room
//  FETCH_WAIT | request accepted, waiting for the word at pc
//  FETCH_DROP | outstanding word is stale after a redirect; discard it on arrival
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_W-1:0]     imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INSTR_W-1:0]    imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_W-1:0]     redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [OPCODE_W-1:0]   instr_opcode,
   output logic [INSTR_W-OPCODE_W-1:0] instr_operand,
   output logic [ADDR_W-1:0]     instr_pc
);

   localparam int OPER_W = INSTR_W - OPCODE_W;
   localparam int ENT_W  = ADDR_W + INSTR_W;
   localparam int CNT_W  = $clog2(FETCH_DEPTH + 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_valid_q, req_valid_d;
   logic              accept, push, pop;
   logic [ENT_W-1:0]  head;
   logic              buf_empty;
   logic [CNT_W-1:0]  cnt_nxt;

   assign accept = req_valid_q && imem_req_ready;
   assign pop    = instr_valid && instr_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      unique case (state_q)
         FETCH_REQ: begin
            if (accept) state_d = redirect_valid ? FETCH_DROP : FETCH_WAIT;
         end
         FETCH_WAIT: begin
            // a word landing in the same cycle as a redirect is already stale
            if (redirect_valid) begin
               state_d = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
            end else if (imem_rsp_valid) begin
               state_d = FETCH_REQ;
               push    = 1'b1;
               pc_d    = pc_q + 1'b1;
            end
         end
         FETCH_DROP: begin
            if (imem_rsp_valid) state_d = FETCH_REQ;
         end
         default: state_d = FETCH_REQ;
      endcase
      if (redirect_valid) pc_d = redirect_pc;
   end

   // request only when the buffer will still have a slot for the word once it returns
   always_comb begin
      req_valid_d = (state_d == FETCH_REQ) && (cnt_nxt < CNT_W'(FETCH_DEPTH));
      addr_d      = pc_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH_REQ;
         pc_q        <= RESET_PC;
         addr_q      <= '0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         req_valid_q <= req_valid_d;
      end
   end

   fetch_unit_buf #(
      .DEPTH (FETCH_DEPTH),
      .W     (ENT_W),
      .CNT_W (CNT_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({pc_q, imem_rsp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .empty     (buf_empty),
      .cnt_nxt   (cnt_nxt)
   );

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = addr_q;
   assign instr_valid    = !buf_empty;
   assign instr_opcode   = head[INSTR_W-1 -: OPCODE_W];
   assign instr_operand  = head[OPER_W-1:0];
   assign instr_pc       = head[ENT_W-1 -: ADDR_W];

   rsp_only_when_outstanding: assert property (
      @(posedge clk) disable iff (rst) imem_rsp_valid |-> (state_q != FETCH_REQ)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected decode words, a monitor pops and compares.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk;
   logic       rst;
   logic       imem_req_valid;
   logic       imem_req_ready;
   logic [7:0] imem_addr;
   logic       imem_rsp_valid;
   logic [7:0] imem_rsp_data;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic [4:0] instr_opcode;
   logic [2:0] instr_operand;
   logic [7:0] instr_pc;

   fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_opcode   (instr_opcode),
      .instr_operand  (instr_operand),
      .instr_pc       (instr_pc)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  mem [256];
   int          mem_lat   = 1;
   bit          mem_stall = 0;
   int          acc_cnt   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void exp_push(input logic [4:0] op, input logic [2:0] oper, input logic [7:0] pc);
      exp_q.push_back({op, oper, pc});
   endfunction

   // memory model: one outstanding read, response mem_lat cycles after acceptance
   initial begin : memory
      bit         pend = 0;
      int         pend_cnt = 0;
      logic [7:0] pend_addr = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         imem_rsp_valid = 1'b0;
         if (pend) begin
            if (pend_cnt <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem[pend_addr];
               pend = 0;
            end else begin
               pend_cnt--;
            end
         end
         imem_req_ready = !mem_stall;
         if (!rst && imem_req_valid && imem_req_ready) begin
            pend      = 1;
            pend_cnt  = mem_lat;
            pend_addr = imem_addr;
            acc_cnt++;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         #1;
         if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {16'h0, instr_opcode, instr_operand, instr_pc}, 32'hFFFF_FFFF);
            end else begin
               check("decode_word", {16'h0, instr_opcode, instr_operand, instr_pc}, {16'h0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [7:0] pc);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      bit done = 0;
      instr_ready = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (exp_q.size() == 0) done = 1;
      end
      instr_ready = 1'b0;
      check(name, 32'(done), 32'd1);
      exp_q.delete();
   endtask

   task automatic wait_accept(input logic [7:0] a, input string name);
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (imem_req_valid && imem_req_ready && imem_addr == a) seen = 1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic outputs_zero(input string tag);
      check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_addr"},      32'(imem_addr),      32'd0);
      check({tag, "_instr_vld"}, 32'(instr_valid),    32'd0);
      check({tag, "_opcode"},    32'(instr_opcode),   32'd0);
      check({tag, "_operand"},   32'(instr_operand),  32'd0);
      check({tag, "_pc"},        32'(instr_pc),       32'd0);
   endtask

   task automatic release_reset(input string tag);
      tick();
      rst = 1'b0;
      @(negedge clk);
      #2;
      check({tag, "_req_before_edge"}, 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      #2;
      check({tag, "_first_req"}, {23'h0, imem_req_valid, imem_addr}, {23'h0, 1'b1, 8'h00});
   endtask

   initial begin : main
      int base;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h08; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22; mem[8'h03] = 8'h33;
      mem[8'h04] = 8'h44; mem[8'h05] = 8'h55; mem[8'h06] = 8'h66; mem[8'h07] = 8'h77;
      mem[8'h10] = 8'h9A; mem[8'h20] = 8'h5C; mem[8'h21] = 8'h6D; mem[8'h30] = 8'h3F;
      mem[8'h40] = 8'hA1; mem[8'h41] = 8'hB2; mem[8'h42] = 8'hC3;
      mem[8'hFE] = 8'hF8; mem[8'hFF] = 8'hE9;

      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;

      // reset values and straight-line fetch from RESET_PC
      @(negedge clk);
      #1;
      outputs_zero("reset");
      repeat (2) tick();
      exp_push(5'd1, 3'd0, 8'h00);
      exp_push(5'd2, 3'd1, 8'h01);
      exp_push(5'd4, 3'd2, 8'h02);
      exp_push(5'd6, 3'd3, 8'h03);
      instr_ready = 1'b1;
      release_reset("reset");
      drain("straight_drain");

      // redirect while the word for 0x02 is outstanding
      mem_lat = 3;
      redirect(8'h00);
      exp_push(5'd1, 3'd0, 8'h00);
      exp_push(5'd2, 3'd1, 8'h01);
      exp_push(5'd20, 3'd1, 8'h40);
      exp_push(5'd22, 3'd2, 8'h41);
      instr_ready = 1'b1;
      wait_accept(8'h02, "accept_0x02");
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      tick();
      redirect_valid = 1'b0;
      drain("redirect_drain");

      // backpressure: buffer fills to DEPTH and requests stop
      mem_lat = 1;
      redirect(8'h04);
      base = acc_cnt;
      repeat (12) tick();
      check("bp_accepts", 32'(acc_cnt - base), 32'(DEPTH));
      check("bp_req_idle", 32'(imem_req_valid), 32'd0);
      check("bp_head", {23'h0, instr_valid, instr_pc}, {23'h0, 1'b1, 8'h04});
      exp_push(5'd8, 3'd4, 8'h04);
      exp_push(5'd10, 3'd5, 8'h05);
      exp_push(5'd12, 3'd6, 8'h06);
      drain("bp_drain");

      // redirect latency from a full idle buffer, then PC wrap
      repeat (8) tick();
      redirect(8'hFE);
      check("redir_latency", {23'h0, imem_req_valid, imem_addr}, {23'h0, 1'b1, 8'hFE});
      exp_push(5'd31, 3'd0, 8'hFE);
      exp_push(5'd29, 3'd1, 8'hFF);
      exp_push(5'd1, 3'd0, 8'h00);
      drain("wrap_drain");

      // request stall: address held, redirect retargets it
      mem_stall = 1;
      redirect(8'h10);
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         check("stall_hold", {23'h0, imem_req_valid, imem_addr}, {23'h0, 1'b1, 8'h10});
      end
      redirect(8'h20);
      check("stall_redirect", {23'h0, imem_req_valid, imem_addr}, {23'h0, 1'b1, 8'h20});
      exp_push(5'd11, 3'd4, 8'h20);
      exp_push(5'd13, 3'd5, 8'h21);
      mem_stall = 0;
      drain("stall_drain");

      // reset while a response is outstanding; the stale word arrives during reset
      mem_lat = 4;
      redirect(8'h30);
      instr_ready = 1'b1;
      wait_accept(8'h30, "accept_0x30");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      outputs_zero("midwait");
      mem_lat = 1;
      repeat (6) @(posedge clk);
      exp_push(5'd1, 3'd0, 8'h00);
      exp_push(5'd2, 3'd1, 8'h01);
      release_reset("midwait");
      drain("midwait_drain");

      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
